// File: rtl/sync_out_generator_pkg.sv
// Shared types and constants for the SYNC_OUT transmit path.
// Holds the SYS_TIME width, the default period and the settings bundle
// that software hands to the generator.
package sync_out_generator_pkg;

  localparam int          SYS_TIME_WIDTH          = 57;
  localparam logic [15:0] SYNC_OUT_PERIOD_DEFAULT = 16'd10240;  // 500 us at 20.48 MHz
  localparam int          DEF_PERIOD_WIDTH        = 16;
  localparam int          DEF_PW_WIDTH            = 8;

  typedef struct packed {
    logic                        UPDATE;
    logic [SYS_TIME_WIDTH-1:0]   START_TIME;
    logic [DEF_PERIOD_WIDTH-1:0] PERIOD;
    logic [DEF_PW_WIDTH-1:0]     PULSE_WIDTH;
  } sync_out_settings_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CATCHUP = 2'd2
  } sync_out_state_t;

endpackage

// File: rtl/sync_out_pulse_stretcher.sv
// Width counter and SYNC_OUT register.
// A trigger loads max(WIDTH,1) and raises the output; the output falls when
// the counter runs down to zero. A retrigger while high reloads the counter,
// so back-to-back pulses merge. CLR truncates any active pulse.
module sync_out_pulse_stretcher #(
  parameter int PW_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TRIG,
  input  logic                CLR,
  input  logic [PW_WIDTH-1:0] WIDTH,
  output logic                SYNC_OUT
);

  logic [PW_WIDTH-1:0] r_cnt;
  logic                r_out;

  // Load on trigger, count down otherwise; clear and reset win over trigger.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (TRIG) begin
      r_cnt <= (WIDTH == '0) ? PW_WIDTH'(1) : WIDTH;
      r_out <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - PW_WIDTH'(1);
      r_out <= (r_cnt != PW_WIDTH'(1));
    end
  end

  assign SYNC_OUT = r_out;

endmodule

// File: rtl/sync_out_generator.sv
// Periodic SYNC_OUT pulse train aligned to programmed SYS_TIME instants.
// A scheduler FSM (IDLE / ARMED / CATCHUP) compares SYS_TIME against the next
// edge time with >= so that 2-tick jumps cannot skip an edge; when more than
// one period late it emits one pulse and then silently steps the schedule
// forward one period per cycle. PERIOD_WIDTH/PW_WIDTH must match the field
// widths of sync_out_settings_t.
// Optional build macro SYNC_OUT_MISS_CNT_EN adds a saturating MISS_CNT port
// counting edges skipped in CATCHUP.
module sync_out_generator
  import sync_out_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int PW_WIDTH     = DEF_PW_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  sync_out_settings_t        SETTINGS,
  input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
  output logic                      SYNC_OUT,
  output logic                      ARMED,
  output logic [31:0]               PULSE_CNT
`ifdef SYNC_OUT_MISS_CNT_EN
  ,
  output logic [15:0]               MISS_CNT
`endif
);

  sync_out_state_t           r_state, w_state_nxt;
  logic [SYS_TIME_WIDTH-1:0] r_next_time, w_next_time_nxt;
  logic [PERIOD_WIDTH-1:0]   r_period;
  logic [PW_WIDTH-1:0]       r_pw;
  logic [31:0]               r_pulse_cnt;
  logic [SYS_TIME_WIDTH-1:0] w_next_plus;
  logic                      w_trig;
  logic                      w_miss;

  assign w_next_plus = r_next_time + {{(SYS_TIME_WIDTH-PERIOD_WIDTH){1'b0}}, r_period};

  // Scheduler next-state: UPDATE overrides any edge match in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_next_time_nxt = r_next_time;
    w_trig          = 1'b0;
    w_miss          = 1'b0;
    if (SETTINGS.UPDATE) begin
      w_state_nxt     = (SETTINGS.PERIOD == '0) ? S_IDLE : S_ARMED;
      w_next_time_nxt = SETTINGS.START_TIME;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (SYS_TIME >= r_next_time) begin
            w_trig          = 1'b1;
            w_next_time_nxt = w_next_plus;
            if (w_next_plus <= SYS_TIME) w_state_nxt = S_CATCHUP;
          end
        end
        S_CATCHUP: begin
          w_next_time_nxt = w_next_plus;
          if (w_next_plus > SYS_TIME) w_state_nxt = S_ARMED;
          else                        w_miss      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scheduler state, edge time and latched settings.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_next_time <= '0;
      r_period    <= '0;
      r_pw        <= '0;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_time <= w_next_time_nxt;
      if (SETTINGS.UPDATE) begin
        r_period    <= SETTINGS.PERIOD;
        r_pw        <= SETTINGS.PULSE_WIDTH;
        r_pulse_cnt <= '0;
      end else if (w_trig) begin
        r_pulse_cnt <= r_pulse_cnt + 32'd1;
      end
    end
  end

`ifdef SYNC_OUT_MISS_CNT_EN
  logic [15:0] r_miss_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Skipped-edge counter, saturating, cleared by UPDATE.
  always_ff @(posedge CLK) begin
    if (RST || SETTINGS.UPDATE) r_miss_cnt <= '0;
    else if (w_miss)            r_miss_cnt <= sat_inc16(r_miss_cnt);
  end

  assign MISS_CNT = r_miss_cnt;
`else
  logic w_miss_unused;
  assign w_miss_unused = w_miss;
`endif

  sync_out_pulse_stretcher #(
    .PW_WIDTH (PW_WIDTH)
  ) u_stretcher (
    .CLK      (CLK),
    .RST      (RST),
    .TRIG     (w_trig),
    .CLR      (SETTINGS.UPDATE),
    .WIDTH    (r_pw),
    .SYNC_OUT (SYNC_OUT)
  );

  assign ARMED     = (r_state != S_IDLE);
  assign PULSE_CNT = r_pulse_cnt;

endmodule

// File: tb/tb_sync_out_generator.sv
// Self-checking bench for sync_out_generator: directed scenarios plus a
// randomized run, each checked against an edge-list reference model.
`timescale 1ns/1ps
module tb_sync_out_generator;
  import sync_out_generator_pkg::*;

  logic               CLK = 1'b0;
  logic               RST;
  sync_out_settings_t SETTINGS;
  logic [56:0]        SYS_TIME;
  logic               SYNC_OUT;
  logic               ARMED;
  logic [31:0]        PULSE_CNT;
`ifdef SYNC_OUT_MISS_CNT_EN
  logic [15:0]        MISS_CNT;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sync_out_generator dut (
    .CLK       (CLK),
    .RST       (RST),
    .SETTINGS  (SETTINGS),
    .SYS_TIME  (SYS_TIME),
    .SYNC_OUT  (SYNC_OUT),
    .ARMED     (ARMED),
    .PULSE_CNT (PULSE_CNT)
`ifdef SYNC_OUT_MISS_CNT_EN
    ,
    .MISS_CNT  (MISS_CNT)
`endif
  );

  // Reference model: the schedule is a target time plus a period; whenever
  // time reaches the target a pulse fires and the target jumps to the first
  // edge strictly after the current time (missed edges are dropped).
  logic [63:0] m_target;
  int unsigned m_period;
  int unsigned m_pw;
  logic [31:0] m_cnt;
  int          m_high;
  bit          m_active;
  logic [56:0] cur_s;

  task automatic drive_cycle(input logic [56:0] s, input bit rst, input bit upd,
                             input logic [56:0] st, input logic [15:0] p, input logic [7:0] w);
    logic [63:0] s64;
    RST                  = rst;
    SYS_TIME             = s;
    cur_s                = s;
    SETTINGS.UPDATE      = upd;
    SETTINGS.START_TIME  = st;
    SETTINGS.PERIOD      = p;
    SETTINGS.PULSE_WIDTH = w;
    s64 = {7'd0, s};
    if (rst) begin
      m_active = 0; m_cnt = 0; m_high = 0; m_target = 0; m_period = 0; m_pw = 0;
    end else if (upd) begin
      m_target = {7'd0, st}; m_period = p; m_pw = w; m_cnt = 0; m_high = 0;
      m_active = (p != 0);
    end else if (m_active && s64 >= m_target) begin
      m_target = m_target + 64'(m_period) * ((s64 - m_target) / 64'(m_period) + 64'd1);
      m_high   = (m_pw == 0) ? 1 : int'(m_pw);
      m_cnt    = m_cnt + 32'd1;
    end else if (m_high > 0) begin
      m_high--;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    checks++;
    if ({SYNC_OUT, ARMED, PULSE_CNT} !== 34'd0) begin
      failures++;
      $display("FAIL reset_state out=%b armed=%b cnt=%0d required 0/0/0", SYNC_OUT, ARMED, PULSE_CNT);
    end
  endtask

  task automatic test_ramp();
    int   rises = 0;
    logic prev  = 1'b0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd0, 0, 1, 57'd1000, 16'd10240, 8'd4);
    for (int i = 0; i < 21500; i++) begin
      drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
      checks++;
      if (SYNC_OUT !== (m_high > 0) || ARMED !== m_active || PULSE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL ramp_model s=%0d out=%b/%b armed=%b/%b cnt=%0d/%0d",
                 cur_s, SYNC_OUT, (m_high > 0), ARMED, m_active, PULSE_CNT, m_cnt);
      end
      if (SYNC_OUT && !prev) begin
        checks++;
        if (cur_s !== 57'(1000 + 10240 * rises)) begin
          failures++;
          $display("FAIL ramp_edge_time rise=%0d s=%0d required %0d", rises, cur_s, 1000 + 10240 * rises);
        end
        rises++;
      end
      prev = SYNC_OUT;
    end
    checks++;
    if (rises != 3 || PULSE_CNT !== 32'd3) begin
      failures++;
      $display("FAIL ramp_count rises=%0d cnt=%0d required 3/3", rises, PULSE_CNT);
    end
  endtask

  task automatic test_jump();
    int   rises = 0;
    logic prev  = 1'b0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd990, 0, 1, 57'd1000, 16'd10240, 8'd4);
    while (cur_s < 57'd11250) begin
      drive_cycle(cur_s + ((cur_s < 57'd998) ? 57'd1 : 57'd2), 0, 0, 57'd0, 16'd0, 8'd0);
      checks++;
      if (SYNC_OUT !== (m_high > 0) || ARMED !== m_active || PULSE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL jump_model s=%0d out=%b/%b armed=%b/%b cnt=%0d/%0d",
                 cur_s, SYNC_OUT, (m_high > 0), ARMED, m_active, PULSE_CNT, m_cnt);
      end
      if (SYNC_OUT && !prev) begin
        checks++;
        if (cur_s !== ((rises == 0) ? 57'd1000 : 57'd11240)) begin
          failures++;
          $display("FAIL jump_edge_time rise=%0d s=%0d", rises, cur_s);
        end
        rises++;
      end
      prev = SYNC_OUT;
      if (cur_s == 57'd1100) begin
        checks++;
        if (rises != 1 || PULSE_CNT !== 32'd1) begin
          failures++;
          $display("FAIL jump_single rises=%0d cnt=%0d required 1/1", rises, PULSE_CNT);
        end
      end
    end
  endtask

  task automatic test_catchup();
    int   rises = 0;
    logic prev  = 1'b0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd400, 0, 1, 57'd100, 16'd50, 8'd3);
    for (int i = 0; i < 72; i++) begin
      drive_cycle((i < 12) ? 57'd400 : cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
      checks++;
      if (SYNC_OUT !== (m_high > 0) || ARMED !== m_active || PULSE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL catchup_model s=%0d out=%b/%b armed=%b/%b cnt=%0d/%0d",
                 cur_s, SYNC_OUT, (m_high > 0), ARMED, m_active, PULSE_CNT, m_cnt);
      end
      if (SYNC_OUT && !prev) begin
        checks++;
        if (cur_s !== ((rises == 0) ? 57'd400 : 57'd450)) begin
          failures++;
          $display("FAIL catchup_edge_time rise=%0d s=%0d", rises, cur_s);
        end
        rises++;
      end
      prev = SYNC_OUT;
      if (i == 11) begin
        checks++;
        if (rises != 1 || PULSE_CNT !== 32'd1 || ARMED !== 1'b1) begin
          failures++;
          $display("FAIL catchup_single rises=%0d cnt=%0d armed=%b required 1/1/1", rises, PULSE_CNT, ARMED);
        end
      end
    end
    checks++;
    if (PULSE_CNT !== 32'd2) begin
      failures++;
      $display("FAIL catchup_resume cnt=%0d required 2", PULSE_CNT);
    end
  endtask

  task automatic test_disable();
    int highs = 0;
    int guard = 0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd0, 0, 1, 57'd5, 16'd100, 8'd10);
    while (SYNC_OUT !== 1'b1 && guard < 50) begin
      drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
      guard++;
    end
    checks++;
    if (SYNC_OUT !== 1'b1) begin
      failures++;
      $display("FAIL disable_first_pulse out=%b required 1 within 50 cycles", SYNC_OUT);
    end
    drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(cur_s + 57'd1, 0, 1, 57'd0, 16'd0, 8'd10);
    checks++;
    if (SYNC_OUT !== 1'b0 || ARMED !== 1'b0 || PULSE_CNT !== 32'd0) begin
      failures++;
      $display("FAIL disable_truncate out=%b armed=%b cnt=%0d required 0/0/0", SYNC_OUT, ARMED, PULSE_CNT);
    end
    for (int i = 0; i < 30000; i++) begin
      drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
      if (SYNC_OUT !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0 || ARMED !== 1'b0 || PULSE_CNT !== 32'd0) begin
      failures++;
      $display("FAIL disable_quiet highs=%0d armed=%b cnt=%0d required 0/0/0", highs, ARMED, PULSE_CNT);
    end
  endtask

  task automatic test_merge();
    int          lows = 0;
    int          gap;
    bit          started = 0;
    logic [31:0] prev_cnt = 32'd0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd0, 0, 1, 57'd10, 16'd8, 8'd20);
    gap = 0;
    for (int i = 0; i < 220; i++) begin
      drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
      checks++;
      if (SYNC_OUT !== (m_high > 0) || ARMED !== m_active || PULSE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL merge_model s=%0d out=%b/%b cnt=%0d/%0d", cur_s, SYNC_OUT, (m_high > 0), PULSE_CNT, m_cnt);
      end
      if (started && SYNC_OUT !== 1'b1) lows++;
      if (SYNC_OUT === 1'b1) started = 1;
      gap++;
      if (PULSE_CNT !== prev_cnt) begin
        if (prev_cnt != 32'd0) begin
          checks++;
          if (gap != 8) begin
            failures++;
            $display("FAIL merge_spacing gap=%0d required 8", gap);
          end
        end
        gap = 0;
        prev_cnt = PULSE_CNT;
      end
    end
    checks++;
    if (lows != 0 || PULSE_CNT !== 32'((220 - 10) / 8 + 1)) begin
      failures++;
      $display("FAIL merge_continuous lows=%0d cnt=%0d required 0/%0d", lows, PULSE_CNT, (220 - 10) / 8 + 1);
    end
  endtask

  task automatic test_hold();
    int highs = 0;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd990, 0, 1, 57'd1000, 16'd10240, 8'd4);
    while (cur_s < 57'd999) drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(57'd999, 0, 0, 57'd0, 16'd0, 8'd0);
      if (SYNC_OUT !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL hold_no_pulse highs=%0d required 0", highs);
    end
    drive_cycle(57'd1000, 0, 0, 57'd0, 16'd0, 8'd0);
    checks++;
    if (SYNC_OUT !== 1'b1 || PULSE_CNT !== 32'd1) begin
      failures++;
      $display("FAIL hold_pulse out=%b cnt=%0d required 1/1", SYNC_OUT, PULSE_CNT);
    end
    drive_cycle(57'd1001, 0, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd1002, 1, 0, 57'd0, 16'd0, 8'd0);
    checks++;
    if ({SYNC_OUT, ARMED, PULSE_CNT} !== 34'd0) begin
      failures++;
      $display("FAIL rst_mid_pulse out=%b armed=%b cnt=%0d required 0/0/0", SYNC_OUT, ARMED, PULSE_CNT);
    end
    for (int i = 0; i < 20; i++) drive_cycle(cur_s + 57'd1, 0, 0, 57'd0, 16'd0, 8'd0);
    checks++;
    if (ARMED !== 1'b0 || SYNC_OUT !== 1'b0) begin
      failures++;
      $display("FAIL rst_schedule_lost armed=%b out=%b required 0/0", ARMED, SYNC_OUT);
    end
  endtask

  task automatic test_random();
    logic [56:0] s;
    logic [15:0] p;
    drive_cycle(57'd0, 1, 0, 57'd0, 16'd0, 8'd0);
    drive_cycle(57'd50, 0, 1, 57'd60, 16'd10, 8'd3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        p = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(3, 40));
        drive_cycle(cur_s, 0, 1, cur_s + 57'($urandom_range(0, 30)), p, 8'($urandom_range(0, 12)));
      end else begin
        if ($urandom_range(0, 99) < 2 && cur_s > 57'd5) s = cur_s - 57'd5;
        else                                             s = cur_s + 57'($urandom_range(0, 2));
        drive_cycle(s, 0, 0, 57'd0, 16'd0, 8'd0);
      end
      checks++;
      if (SYNC_OUT !== (m_high > 0) || ARMED !== m_active || PULSE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL random_model i=%0d s=%0d out=%b/%b armed=%b/%b cnt=%0d/%0d",
                 i, cur_s, SYNC_OUT, (m_high > 0), ARMED, m_active, PULSE_CNT, m_cnt);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    SYS_TIME = '0;
    SETTINGS = '0;
    cur_s = '0;
    m_target = '0; m_period = 0; m_pw = 0; m_cnt = '0; m_high = 0; m_active = 0;
    test_reset();
    test_ramp();
    test_jump();
    test_catchup();
    test_disable();
    test_merge();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
